// File: rtl/alu_pkg.sv
// Shared types and constants for the 8086 ALU sequencer and its combinational ALU.
package alu_pkg;

    localparam int unsigned WORD_W  = 16;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned FLAGS_W = 12;
    localparam int unsigned REG_W   = 3;
    localparam int unsigned MODE_W  = 3;

    localparam logic [MODE_W-1:0] ALU_ADD = 3'd0;
    localparam logic [MODE_W-1:0] ALU_OR  = 3'd1;
    localparam logic [MODE_W-1:0] ALU_ADC = 3'd2;
    localparam logic [MODE_W-1:0] ALU_SBB = 3'd3;
    localparam logic [MODE_W-1:0] ALU_AND = 3'd4;
    localparam logic [MODE_W-1:0] ALU_SUB = 3'd5;
    localparam logic [MODE_W-1:0] ALU_XOR = 3'd6;
    localparam logic [MODE_W-1:0] ALU_CMP = 3'd7;

    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_P = 2;
    localparam int unsigned FLAG_A = 4;
    localparam int unsigned FLAG_Z = 6;
    localparam int unsigned FLAG_S = 7;
    localparam int unsigned FLAG_T = 8;
    localparam int unsigned FLAG_I = 9;
    localparam int unsigned FLAG_D = 10;
    localparam int unsigned FLAG_O = 11;

    localparam logic [FLAGS_W-1:0] FLAGS_RESET = 12'h002;

    typedef enum logic [2:0] {
        ST_OPC,
        ST_MODRM,
        ST_IMM_LO,
        ST_IMM_HI,
        ST_EXEC
    } state_e;

    // Per-instruction decode latched at opcode accept.
    typedef struct packed {
        logic [MODE_W-1:0] mode;
        logic              word;
        logic              dir;
        logic              use_imm;
        logic              grp;
        logic              imm16;
        logic              sext;
    } decode_t;

    // Byte register r lives in word register r&3; word registers map directly.
    function automatic logic [REG_W-1:0] word_index(input logic [REG_W-1:0] r, input logic word);
        return word ? r : {1'b0, r[1:0]};
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 8/16-bit integer ALU: eight arithmetic/logic modes producing result and FLAGS.
module alu
    import alu_pkg::*;
(
    input  logic [MODE_W-1:0]  mode_i,
    input  logic               word_i,
    input  logic [WORD_W-1:0]  op1_i,
    input  logic [WORD_W-1:0]  op2_i,
    input  logic [FLAGS_W-1:0] flags_i,
    output logic [WORD_W-1:0]  res_o,
    output logic [FLAGS_W-1:0] flags_o
);

    localparam int unsigned WIDE_W = WORD_W + 1;

    logic              cin;
    logic              arith;
    logic              is_sub;
    logic [WIDE_W-1:0] wide;
    logic              sign_a;
    logic              sign_b;
    logic              sign_r;
    logic              carry;
    logic              aux;
    logic              ovf;
    logic              zero;

    // Byte operands arrive zero-extended, so bit 8 of the wide result is the byte carry/borrow.
    always_comb begin
        cin    = flags_i[FLAG_C];
        arith  = 1'b1;
        is_sub = 1'b0;
        wide   = '0;
        case (mode_i)
            ALU_ADD: wide = {1'b0, op1_i} + {1'b0, op2_i};
            ALU_ADC: wide = {1'b0, op1_i} + {1'b0, op2_i} + WIDE_W'(cin);
            ALU_SBB: begin
                is_sub = 1'b1;
                wide   = {1'b0, op1_i} - {1'b0, op2_i} - WIDE_W'(cin);
            end
            ALU_SUB, ALU_CMP: begin
                is_sub = 1'b1;
                wide   = {1'b0, op1_i} - {1'b0, op2_i};
            end
            ALU_OR: begin
                arith = 1'b0;
                wide  = {1'b0, op1_i | op2_i};
            end
            ALU_AND: begin
                arith = 1'b0;
                wide  = {1'b0, op1_i & op2_i};
            end
            default: begin
                arith = 1'b0;
                wide  = {1'b0, op1_i ^ op2_i};
            end
        endcase

        sign_a = word_i ? op1_i[WORD_W-1] : op1_i[BYTE_W-1];
        sign_b = word_i ? op2_i[WORD_W-1] : op2_i[BYTE_W-1];
        sign_r = word_i ? wide[WORD_W-1]  : wide[BYTE_W-1];
        carry  = word_i ? wide[WORD_W]    : wide[BYTE_W];
        aux    = op1_i[4] ^ op2_i[4] ^ wide[4];
        ovf    = is_sub ? ((sign_a != sign_b) && (sign_r != sign_a))
                        : ((sign_a == sign_b) && (sign_r != sign_a));
        zero   = word_i ? (wide[WORD_W-1:0] == '0) : (wide[BYTE_W-1:0] == '0);

        res_o           = wide[WORD_W-1:0];
        flags_o         = flags_i;
        flags_o[FLAG_C] = arith & carry;
        flags_o[FLAG_P] = ~^wide[BYTE_W-1:0];
        flags_o[FLAG_A] = arith & aux;
        flags_o[FLAG_Z] = zero;
        flags_o[FLAG_S] = sign_r;
        flags_o[FLAG_O] = arith & ovf;
    end

endmodule

// File: rtl/alu_dispatch.sv
// Byte-stream sequencer for register/immediate ALU instructions: decodes, reads the
// register file, drives the ALU, writes back byte-merged results and owns FLAGS.
module alu_dispatch
    import alu_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic [BYTE_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [REG_W-1:0]   rf_addr_a,
    input  logic [WORD_W-1:0]  rf_data_a,
    output logic [REG_W-1:0]   rf_addr_b,
    input  logic [WORD_W-1:0]  rf_data_b,
    output logic               rf_we,
    output logic [REG_W-1:0]   rf_waddr,
    output logic [WORD_W-1:0]  rf_wdata,
    output logic [FLAGS_W-1:0] flags,
    output logic               done,
    output logic               bad
);

    state_e              state_q;
    decode_t             dec_q;
    logic [REG_W-1:0]    addr_a_q;
    logic [REG_W-1:0]    addr_b_q;
    logic                dst_hi_q;
    logic                src_hi_q;
    logic [WORD_W-1:0]   imm_q;
    logic [FLAGS_W-1:0]  flags_q;
    logic                bad_q;

    logic                xfer;
    decode_t             opc_dec;
    logic                opc_ok;
    state_e              opc_next;
    logic                mod_ok;
    logic [REG_W-1:0]    m_reg;
    logic [REG_W-1:0]    m_rm;
    logic [REG_W-1:0]    dst_sel;
    logic [REG_W-1:0]    src_sel;
    logic [BYTE_W-1:0]   imm_ext;

    logic [WORD_W-1:0]   alu_op1;
    logic [WORD_W-1:0]   alu_op2;
    logic [WORD_W-1:0]   alu_res;
    logic [FLAGS_W-1:0]  flags_d;

    assign xfer = in_valid & in_ready;

    // Opcode classification for the byte currently on in_data.
    always_comb begin
        opc_dec  = '0;
        opc_ok   = 1'b0;
        opc_next = ST_OPC;
        if ((in_data[7:6] == 2'b00) && (in_data[2:0] <= 3'd5)) begin
            opc_ok       = 1'b1;
            opc_dec.mode = in_data[5:3];
            opc_dec.word = in_data[0];
            opc_dec.dir  = in_data[1];
            if (in_data[2]) begin
                opc_dec.use_imm = 1'b1;
                opc_dec.imm16   = in_data[0];
                opc_next        = ST_IMM_LO;
            end else begin
                opc_next = ST_MODRM;
            end
        end else if ((in_data == 8'h80) || (in_data == 8'h81) || (in_data == 8'h83)) begin
            opc_ok          = 1'b1;
            opc_dec.grp     = 1'b1;
            opc_dec.use_imm = 1'b1;
            opc_dec.word    = in_data[0];
            opc_dec.imm16   = (in_data == 8'h81);
            opc_dec.sext    = (in_data == 8'h83);
            opc_next        = ST_MODRM;
        end
    end

    // ModRM field split and d-bit operand routing.
    always_comb begin
        mod_ok  = (in_data[7:6] == 2'b11);
        m_reg   = in_data[5:3];
        m_rm    = in_data[2:0];
        dst_sel = dec_q.dir ? m_reg : m_rm;
        src_sel = dec_q.dir ? m_rm  : m_reg;
        imm_ext = dec_q.sext ? {BYTE_W{in_data[BYTE_W-1]}} : '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_OPC;
            dec_q    <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            dst_hi_q <= 1'b0;
            src_hi_q <= 1'b0;
            imm_q    <= '0;
            flags_q  <= FLAGS_RESET;
            bad_q    <= 1'b0;
        end else begin
            bad_q <= 1'b0;
            case (state_q)
                ST_OPC: begin
                    // Cleared addresses double as the AL/AX destination of the 04h/05h forms.
                    if (xfer) begin
                        if (opc_ok) begin
                            dec_q    <= opc_dec;
                            state_q  <= opc_next;
                            addr_a_q <= '0;
                            addr_b_q <= '0;
                            dst_hi_q <= 1'b0;
                            src_hi_q <= 1'b0;
                            imm_q    <= '0;
                        end else begin
                            bad_q <= 1'b1;
                        end
                    end
                end
                ST_MODRM: begin
                    if (xfer) begin
                        if (!mod_ok) begin
                            bad_q   <= 1'b1;
                            state_q <= ST_OPC;
                        end else if (dec_q.grp) begin
                            dec_q.mode <= m_reg;
                            addr_a_q   <= word_index(m_rm, dec_q.word);
                            dst_hi_q   <= m_rm[2] & ~dec_q.word;
                            state_q    <= ST_IMM_LO;
                        end else begin
                            addr_a_q <= word_index(dst_sel, dec_q.word);
                            addr_b_q <= word_index(src_sel, dec_q.word);
                            dst_hi_q <= dst_sel[2] & ~dec_q.word;
                            src_hi_q <= src_sel[2] & ~dec_q.word;
                            state_q  <= ST_EXEC;
                        end
                    end
                end
                ST_IMM_LO: begin
                    if (xfer) begin
                        imm_q   <= {imm_ext, in_data};
                        state_q <= dec_q.imm16 ? ST_IMM_HI : ST_EXEC;
                    end
                end
                ST_IMM_HI: begin
                    if (xfer) begin
                        imm_q[WORD_W-1:BYTE_W] <= in_data;
                        state_q                <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    flags_q <= flags_d;
                    state_q <= ST_OPC;
                end
                default: state_q <= ST_OPC;
            endcase
        end
    end

    // Lane selection into the ALU and byte merge on the way back.
    always_comb begin
        if (dec_q.word) begin
            alu_op1 = rf_data_a;
        end else begin
            alu_op1 = {{BYTE_W{1'b0}}, dst_hi_q ? rf_data_a[WORD_W-1:BYTE_W] : rf_data_a[BYTE_W-1:0]};
        end

        if (dec_q.use_imm) begin
            alu_op2 = dec_q.word ? imm_q : {{BYTE_W{1'b0}}, imm_q[BYTE_W-1:0]};
        end else if (dec_q.word) begin
            alu_op2 = rf_data_b;
        end else begin
            alu_op2 = {{BYTE_W{1'b0}}, src_hi_q ? rf_data_b[WORD_W-1:BYTE_W] : rf_data_b[BYTE_W-1:0]};
        end

        if (dec_q.word) begin
            rf_wdata = alu_res;
        end else if (dst_hi_q) begin
            rf_wdata = {alu_res[BYTE_W-1:0], rf_data_a[BYTE_W-1:0]};
        end else begin
            rf_wdata = {rf_data_a[WORD_W-1:BYTE_W], alu_res[BYTE_W-1:0]};
        end
    end

    alu u_alu (
        .mode_i  (dec_q.mode),
        .word_i  (dec_q.word),
        .op1_i   (alu_op1),
        .op2_i   (alu_op2),
        .flags_i (flags_q),
        .res_o   (alu_res),
        .flags_o (flags_d)
    );

    assign in_ready  = (state_q != ST_EXEC);
    assign done      = (state_q == ST_EXEC);
    assign rf_we     = done && (dec_q.mode != ALU_CMP);
    assign rf_waddr  = addr_a_q;
    assign rf_addr_a = addr_a_q;
    assign rf_addr_b = addr_b_q;
    assign flags     = flags_q;
    assign bad       = bad_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Randomized bench for alu_dispatch against an arithmetic reference model of the 8086 ALU forms.
module tb_alu_dispatch;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  rf_addr_a;
    logic [15:0] rf_data_a;
    logic [2:0]  rf_addr_b;
    logic [15:0] rf_data_b;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [11:0] flags;
    logic        done;
    logic        bad;

    logic [15:0] rf [8];
    logic        pre_we;
    logic [2:0]  pre_addr;
    logic [15:0] pre_data;
    int          cyc = 0;
    int          wr_cnt = 0;

    logic [15:0] exp_rf [8];
    logic [11:0] exp_flags;
    int          exp_wr;
    int          n_checks = 0;
    int          n_errors = 0;

    alu_dispatch dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rf_addr_a (rf_addr_a),
        .rf_data_a (rf_data_a),
        .rf_addr_b (rf_addr_b),
        .rf_data_b (rf_data_b),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .flags     (flags),
        .done      (done),
        .bad       (bad)
    );

    always #5 clock = ~clock;

    assign rf_data_a = rf[rf_addr_a];
    assign rf_data_b = rf[rf_addr_b];

    // Register file: DUT writes take priority over bench preloads.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (rf_we) begin
            rf[rf_waddr] <= rf_wdata;
            wr_cnt       <= wr_cnt + 1;
        end else if (pre_we) begin
            rf[pre_addr] <= pre_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic set_reg(input int r, input logic [15:0] v);
        @(negedge clock);
        pre_we   = 1'b1;
        pre_addr = 3'(r);
        pre_data = v;
        exp_rf[r] = v;
        @(negedge clock);
        pre_we = 1'b0;
    endtask

    function automatic int get_r(input int r, input bit w);
        if (w) return int'(exp_rf[r]);
        if (r < 4) return int'(exp_rf[r][7:0]);
        return int'(exp_rf[r-4][15:8]);
    endfunction

    task automatic set_r(input int r, input bit w, input int v);
        if (w) exp_rf[r] = 16'(v);
        else if (r < 4) exp_rf[r][7:0] = 8'(v);
        else exp_rf[r-4][15:8] = 8'(v);
    endtask

    function automatic bit valid_op(input logic [7:0] op);
        return ((op < 8'h40) && (op[2:0] <= 3'd5)) || (op == 8'h80) || (op == 8'h81) || (op == 8'h83);
    endfunction

    // Reference: decode bytes, compute result and flags with plain integer arithmetic.
    task automatic model_exec(input logic [7:0] b [4], output bit is_cmp);
        logic [7:0] op;
        int mode, dst, src, a, bv, cin, r, res, s, sa, sb, maxv, half;
        bit w, c, ax, o;
        op = b[0];
        if (op < 8'h40) begin
            mode = int'(op[5:3]);
            w    = op[0];
            if (op[2:0] < 3'd4) begin
                dst = op[1] ? int'(b[1][5:3]) : int'(b[1][2:0]);
                src = op[1] ? int'(b[1][2:0]) : int'(b[1][5:3]);
                a   = get_r(dst, w);
                bv  = get_r(src, w);
            end else begin
                dst = 0;
                a   = get_r(0, w);
                bv  = w ? int'({b[2], b[1]}) : int'(b[1]);
            end
        end else begin
            mode = int'(b[1][5:3]);
            dst  = int'(b[1][2:0]);
            w    = (op != 8'h80);
            a    = get_r(dst, w);
            if (op == 8'h80) bv = int'(b[2]);
            else if (op == 8'h81) bv = int'({b[3], b[2]});
            else bv = (b[2] >= 8'h80) ? int'(b[2]) + 65280 : int'(b[2]);
        end
        maxv = w ? 65535 : 255;
        half = w ? 32768 : 128;
        sa = (a >= half) ? a - 2 * half : a;
        sb = (bv >= half) ? bv - 2 * half : bv;
        c = 1'b0; ax = 1'b0; o = 1'b0;
        case (mode)
            0, 2: begin
                cin = (mode == 2) ? int'(exp_flags[0]) : 0;
                r   = a + bv + cin;
                c   = (r > maxv);
                ax  = ((a % 16) + (bv % 16) + cin) > 15;
                s   = sa + sb + cin;
                o   = (s >= half) || (s < -half);
                res = r & maxv;
            end
            3, 5, 7: begin
                cin = (mode == 3) ? int'(exp_flags[0]) : 0;
                c   = (a < bv + cin);
                ax  = (a % 16) < ((bv % 16) + cin);
                s   = sa - sb - cin;
                o   = (s >= half) || (s < -half);
                res = (a - bv - cin) & maxv;
            end
            1:       res = a | bv;
            4:       res = a & bv;
            default: res = a ^ bv;
        endcase
        exp_flags[0]  = c;
        exp_flags[2]  = ($countones(res & 255) % 2) == 0;
        exp_flags[4]  = ax;
        exp_flags[6]  = (res == 0);
        exp_flags[7]  = (res >= half);
        exp_flags[11] = o;
        is_cmp = (mode == 7);
        if (!is_cmp) begin
            set_r(dst, w, res);
            exp_wr++;
        end
    endtask

    task automatic check_state();
        chk("flags", 32'(flags), 32'(exp_flags));
        for (int r = 0; r < 8; r++) chk($sformatf("rf%0d", r), 32'(rf[r]), 32'(exp_rf[r]));
        chk("wr_count", 32'(wr_cnt), 32'(exp_wr));
    endtask

    // kind: 0 = executes, 1 = rejected with bad, 2 = abandoned after n bytes.
    task automatic run_instr(input logic [7:0] b [4], input int n, input int kind, input bit stall);
        int  acc_cyc;
        int  guard;
        bit  accepted;
        bit  is_cmp;
        acc_cyc = 0;
        for (int i = 0; i < n; i++) begin
            accepted = 1'b0;
            guard    = 0;
            while (!accepted && guard < 40) begin
                @(negedge clock);
                if (i == 0 && guard == 0) check_state();
                in_data  = b[i];
                in_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                accepted = in_valid && in_ready;
                if (accepted && i == 0) acc_cyc = cyc;
                guard++;
            end
            chk($sformatf("accept_byte%0d", i), 32'(accepted), 32'(1));
        end
        if (kind == 2) return;
        @(negedge clock);
        in_valid = 1'b0;
        if (kind == 1) begin
            chk("bad_pulse", 32'(bad), 32'(1));
            chk("no_done_on_bad", 32'(done), 32'(0));
        end else begin
            chk("done", 32'(done), 32'(1));
            chk("in_ready_exec", 32'(in_ready), 32'(0));
            if (!stall) chk("latency", 32'(cyc - acc_cyc + 1), 32'(n + 1));
            model_exec(b, is_cmp);
            chk("rf_we_exec", 32'(rf_we), 32'(!is_cmp));
        end
    endtask

    task automatic gen(output logic [7:0] b [4], output int n, output int kind);
        int sel, k;
        logic [2:0] mode;
        logic w;
        logic [7:0] op;
        sel  = $urandom_range(0, 11);
        mode = 3'($urandom_range(0, 7));
        w    = 1'($urandom_range(0, 1));
        for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
        kind = 0;
        n    = 2;
        if (sel < 5) begin
            b[0] = {2'b00, mode, 1'b0, 1'($urandom_range(0, 1)), w};
            b[1][7:6] = 2'b11;
        end else if (sel < 7) begin
            b[0] = {2'b00, mode, 2'b10, w};
            n    = w ? 3 : 2;
        end else if (sel < 9) begin
            k    = $urandom_range(0, 2);
            op   = (k == 0) ? 8'h80 : ((k == 1) ? 8'h81 : 8'h83);
            b[0] = op;
            b[1] = {2'b11, mode, b[1][2:0]};
            n    = (op == 8'h81) ? 4 : 3;
        end else if (sel < 11) begin
            b[0] = (sel == 9) ? {2'b00, mode, 1'b0, 1'($urandom_range(0, 1)), w} : 8'h81;
            b[1][7:6] = 2'($urandom_range(0, 2));
            kind = 1;
        end else begin
            op = 8'($urandom);
            while (valid_op(op)) op = 8'($urandom);
            b[0] = op;
            n    = 1;
            kind = 1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [7:0] pb [4];
        int n, kind;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        pre_we    = 1'b0;
        pre_addr  = 3'd0;
        pre_data  = 16'h0;
        exp_flags = 12'h002;
        exp_wr    = 0;
        repeat (2) @(negedge clock);
        chk("reset_flags", 32'(flags), 32'(12'h002));
        chk("reset_done", 32'(done), 32'(0));
        chk("reset_bad", 32'(bad), 32'(0));
        chk("reset_rf_we", 32'(rf_we), 32'(0));
        chk("reset_in_ready", 32'(in_ready), 32'(1));
        reset = 1'b0;
        for (int r = 0; r < 8; r++) set_reg(r, 16'($urandom));

        // ADD AL,7Fh with AX=0001h.
        set_reg(0, 16'h0001);
        pb = '{8'h04, 8'h7F, 8'h00, 8'h00};
        run_instr(pb, 2, 0, 1'b0);
        @(negedge clock);
        chk("add_al_ax", 32'(rf[0]), 32'(16'h0080));
        chk("add_al_flags", 32'(flags), 32'(12'h892));

        // CMP AX,8000h with AX=8000h.
        set_reg(0, 16'h8000);
        pb = '{8'h3D, 8'h00, 8'h80, 8'h00};
        run_instr(pb, 3, 0, 1'b0);
        @(negedge clock);
        chk("cmp_ax_unchanged", 32'(rf[0]), 32'(16'h8000));
        chk("cmp_z", 32'(flags[6]), 32'(1));
        chk("cmp_c", 32'(flags[0]), 32'(0));

        // XOR AL,AH with AX=5AA5h.
        set_reg(0, 16'h5AA5);
        pb = '{8'h30, 8'hE0, 8'h00, 8'h00};
        run_instr(pb, 2, 0, 1'b0);
        @(negedge clock);
        chk("xor_ax", 32'(rf[0]), 32'(16'h5AFF));
        chk("xor_s", 32'(flags[7]), 32'(1));
        chk("xor_c", 32'(flags[0]), 32'(0));
        chk("xor_o", 32'(flags[11]), 32'(0));

        // ADD BX,-1 via sign-extended imm8 with BX=0000h.
        set_reg(3, 16'h0000);
        pb = '{8'h83, 8'hC3, 8'hFF, 8'h00};
        run_instr(pb, 3, 0, 1'b0);
        @(negedge clock);
        chk("sext_bx", 32'(rf[3]), 32'(16'hFFFF));
        chk("sext_c", 32'(flags[0]), 32'(0));
        chk("sext_s", 32'(flags[7]), 32'(1));

        // Memory form rejected, then a normal ADD AL,BL.
        pb = '{8'h01, 8'h07, 8'h00, 8'h00};
        run_instr(pb, 2, 1, 1'b0);
        pb = '{8'h00, 8'hD8, 8'h00, 8'h00};
        run_instr(pb, 2, 0, 1'b0);

        // Reset between IMM_LO and IMM_HI of ADD AX,1234h.
        pb = '{8'h81, 8'hC0, 8'h34, 8'h12};
        run_instr(pb, 3, 2, 1'b0);
        @(negedge clock);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clock);
        reset     = 1'b0;
        exp_flags = 12'h002;
        chk("midreset_flags", 32'(flags), 32'(12'h002));
        chk("midreset_in_ready", 32'(in_ready), 32'(1));
        pb = '{8'h05, 8'h34, 8'h12, 8'h00};
        run_instr(pb, 3, 0, 1'b0);

        for (int k = 0; k < 150; k++) begin
            gen(pb, n, kind);
            run_instr(pb, n, kind, ($urandom_range(0, 3) == 0));
        end

        @(negedge clock);
        in_valid = 1'b0;
        check_state();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
